spi_master_cfg: RTL

Parametrised, run-time configurable SPI master, successor to the fixed 8-bit single-slave master.
- Programmable word width and SCLK divider.
- All four CPOL/CPHA modes, selectable MSB/LSB-first.
- Multiple active-low slave selects.
- Start/busy/done handshake for the host-side controller.
Sits between a host control FSM and external SPI slaves; one transfer per start pulse, full duplex.

---
 rtl/spi_master_cfg_if.sv | 21 ++
 rtl/spi_master_cfg.sv | 92 +++++++++
 2 files changed

// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: host/SPI bundle for spi_master_cfg
//   master: start, cpol, cpha, lsb_first, ss_sel, data_in, miso in; sclk, mosi, ss_n, busy, done, data_out out
//   slave:  mirror image, for the controller/bench side
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int SEL_W  = 1
);
  logic start, cpol, cpha, lsb_first, miso, sclk, mosi, busy, done;
  logic [SEL_W-1:0] ss_sel;
  logic [DATA_W-1:0] data_in, data_out;
  logic [NUM_SS-1:0] ss_n;
  modport master(
    input  start, cpol, cpha, lsb_first, ss_sel, data_in, miso,
    output sclk, mosi, ss_n, busy, done, data_out
  );
  modport slave(
    output start, cpol, cpha, lsb_first, ss_sel, data_in, miso,
    input  sclk, mosi, ss_n, busy, done, data_out
  );
endinterface

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: run-time configurable full-duplex SPI master (CPOL/CPHA, MSB/LSB-first, multi-slave)
//   clk, rst: clock and synchronous active-high reset
//   bus (master modport): start/busy/done handshake, per-transfer config, serial lines, received word
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_SS  = 2,
  parameter int SEL_W   = 1
) (
  input logic clk,
  input logic rst,
  spi_master_cfg_if.master bus
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_W + 1);
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hp;
  logic [DATA_W-1:0] tx, rx;
  logic cpha_l, lsb_l;
  logic [NUM_SS-1:0] ss_dec;
  logic last_cnt, tgl, lead_e, first_e, last_e, smp, adv;
  // hp counts sclk edges already issued; the edge being issued now is hp+1
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) ss_dec[i] = bus.ss_sel != SEL_W'(i);
    last_cnt = cnt == CW'(CLK_DIV - 1);
    tgl = (state == LEAD || state == XFER) && last_cnt && hp != HW'(2 * DATA_W);
    lead_e = !hp[0];
    first_e = hp == '0;
    last_e = hp == HW'(2 * DATA_W - 1);
    // miso is taken just before sclk moves, so it is the value the slave set up a half-period earlier
    smp = tgl && (lead_e ^ cpha_l);
    adv = tgl && (cpha_l ? lead_e && !first_e : !lead_e && !last_e);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hp <= '0;
      tx <= '0;
      rx <= '0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      bus.sclk <= 1'b0;
      bus.mosi <= 1'b0;
      bus.ss_n <= '1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.done <= 1'b0;
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (smp) rx <= lsb_l ? {bus.miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], bus.miso};
      if (adv) begin
        tx <= lsb_l ? tx >> 1 : tx << 1;
        bus.mosi <= lsb_l ? tx[1] : tx[DATA_W-2];
      end
      if (tgl) begin
        bus.sclk <= ~bus.sclk;
        hp <= hp + 1'b1;
      end
      case (state)
        IDLE: begin
          bus.sclk <= bus.cpol;
          cnt <= '0;
          if (bus.start) begin
            state <= LEAD;
            hp <= '0;
            tx <= bus.data_in;
            cpha_l <= bus.cpha;
            lsb_l <= bus.lsb_first;
            bus.busy <= 1'b1;
            bus.ss_n <= ss_dec;
            bus.mosi <= bus.lsb_first ? bus.data_in[0] : bus.data_in[DATA_W-1];
          end
        end
        LEAD: if (tgl) state <= XFER;
        XFER: if (last_cnt && !tgl) state <= TRAIL;
        TRAIL: if (last_cnt) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.ss_n <= '1;
          bus.done <= 1'b1;
          bus.data_out <= rx;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
